// File: rtl/matrix_loader_pkg.sv
// ============================================================================
// matrix_loader_pkg : shared matrix-multiply defaults and loader state encoding
// Rev 1.0
// ============================================================================
`default_nettype none

package matrix_loader_pkg;

  localparam int c_data_width = 32;
  localparam int c_size       = 6;
  localparam int c_n_w        = 4;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD_A    = 3'd1,
    LOAD_B    = 3'd2,
    FIRE      = 3'd3,
    WAIT_DONE = 3'd4
  } state_t;

  // A dimension is usable only when it is non-zero and fits the flat buses.
  function automatic logic legal_n(input logic [c_n_w-1:0] n, input int size);
    return (n != '0) && (int'(n) <= size);
  endfunction

endpackage

`default_nettype wire

// File: rtl/matrix_loader_rc.sv
// ============================================================================
// rc_counter : row/col walker over an N x N matrix with last-element flag
// Rev 1.0
// ============================================================================
`default_nettype none

module rc_counter
  import matrix_loader_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_adv,
  input  logic [c_n_w-1:0] i_n,
  output logic [c_n_w-1:0] o_row,
  output logic [c_n_w-1:0] o_col,
  output logic             o_last
);

  logic [c_n_w-1:0] r_row;
  logic [c_n_w-1:0] r_col;
  logic [c_n_w-1:0] w_n_m1;
  logic             w_col_end;
  logic             w_row_end;

  assign w_n_m1    = i_n - c_n_w'(1);
  assign w_col_end = (r_col == w_n_m1);
  assign w_row_end = (r_row == w_n_m1);

  // Wrapping to (0,0) on the final element lets the next matrix start cleanly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_clr) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_adv) begin
      if (w_col_end) begin
        r_col <= '0;
        r_row <= w_row_end ? '0 : r_row + c_n_w'(1);
      end else begin
        r_col <= r_col + c_n_w'(1);
      end
    end
  end

  assign o_row  = r_row;
  assign o_col  = r_col;
  assign o_last = w_col_end && w_row_end;

endmodule

`default_nettype wire

// File: rtl/matrix_loader.sv
// ============================================================================
// matrix_loader : streams A then B (row-major) into packed buses, pulses START
// Rev 1.0
// ============================================================================
`default_nettype none

module matrix_loader
  import matrix_loader_pkg::*;
#(
  parameter int DATA_WIDTH = c_data_width,
  parameter int SIZE       = c_size,
  parameter int ARRAY_SIZE = SIZE * SIZE
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [3:0]                       N,
  input  logic                             load_start,
  input  logic                             in_valid,
  input  logic [DATA_WIDTH-1:0]            in_data,
  output logic                             in_ready,
  input  logic                             GLOBAL_DONE,
  output logic [ARRAY_SIZE*DATA_WIDTH-1:0] A_matrix,
  output logic [ARRAY_SIZE*DATA_WIDTH-1:0] B_matrix,
  output logic                             START,
  output logic                             busy,
  output logic                             size_err
);

  localparam int c_idx_w = $clog2(ARRAY_SIZE + 1);
  localparam int c_bus_w = ARRAY_SIZE * DATA_WIDTH;

  state_t               r_state;
  logic [c_n_w-1:0]     r_n;
  logic [c_bus_w-1:0]   r_a;
  logic [c_bus_w-1:0]   r_b;
  logic                 r_start;
  logic                 r_busy;
  logic                 r_ready;
  logic                 r_err;

  logic [c_n_w-1:0]     w_row;
  logic [c_n_w-1:0]     w_col;
  logic                 w_last;
  logic                 w_xfer;
  logic                 w_accept;
  logic [c_idx_w-1:0]   w_elem;

  assign w_xfer   = in_valid && r_ready;
  assign w_accept = (r_state == IDLE) && load_start && legal_n(N, SIZE);
  // Element slots are laid out on the SIZE grid, not the N grid.
  assign w_elem   = c_idx_w'(w_row) * c_idx_w'(SIZE) + c_idx_w'(w_col);

  rc_counter u_rc (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_accept),
    .i_adv  (w_xfer),
    .i_n    (r_n),
    .o_row  (w_row),
    .o_col  (w_col),
    .o_last (w_last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_n     <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_start <= 1'b0;
      r_busy  <= 1'b0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (load_start) begin
            if (w_accept) begin
              r_n     <= N;
              r_a     <= '0;
              r_b     <= '0;
              r_err   <= 1'b0;
              r_busy  <= 1'b1;
              r_ready <= 1'b1;
              r_state <= LOAD_A;
            end else begin
              r_err   <= 1'b1;
            end
          end
        end
        LOAD_A: begin
          if (w_xfer) begin
            for (int e = 0; e < ARRAY_SIZE; e++) begin
              if (w_elem == c_idx_w'(e))
                r_a[(ARRAY_SIZE-e)*DATA_WIDTH-1 -: DATA_WIDTH] <= in_data;
            end
            if (w_last) r_state <= LOAD_B;
          end
        end
        LOAD_B: begin
          if (w_xfer) begin
            for (int e = 0; e < ARRAY_SIZE; e++) begin
              if (w_elem == c_idx_w'(e))
                r_b[(ARRAY_SIZE-e)*DATA_WIDTH-1 -: DATA_WIDTH] <= in_data;
            end
            if (w_last) begin
              r_ready <= 1'b0;
              r_start <= 1'b1;
              r_state <= FIRE;
            end
          end
        end
        FIRE: begin
          r_start <= 1'b0;
          r_state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (GLOBAL_DONE) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_start <= 1'b0;
          r_busy  <= 1'b0;
          r_ready <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign A_matrix = r_a;
  assign B_matrix = r_b;
  assign START    = r_start;
  assign busy     = r_busy;
  assign in_ready = r_ready;
  assign size_err = r_err;

endmodule

`default_nettype wire

// File: tb/tb_matrix_loader.sv
// ============================================================================
// tb_matrix_loader : table-driven loads with a START-time scoreboard
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_matrix_loader;

  localparam int DW  = 32;
  localparam int SZ  = 6;
  localparam int AS  = SZ * SZ;
  localparam int TOT = AS * DW;

  logic           clk = 1'b0;
  logic           rst;
  logic [3:0]     N;
  logic           load_start;
  logic           in_valid;
  logic [DW-1:0]  in_data;
  logic           in_ready;
  logic           GLOBAL_DONE;
  logic [TOT-1:0] A_matrix;
  logic [TOT-1:0] B_matrix;
  logic           START;
  logic           busy;
  logic           size_err;

  typedef struct {
    logic [TOT-1:0] a;
    logic [TOT-1:0] b;
  } exp_t;

  typedef struct {
    int n;
    bit gap;
    int base;
    int step;
    bit poke;
  } load_rec_t;

  typedef struct {
    int n;
    bit exp_err;
  } bad_rec_t;

  exp_t           sb[$];
  logic [TOT-1:0] last_a;
  logic [TOT-1:0] last_b;
  int             checks    = 0;
  int             failures  = 0;
  int             start_cnt = 0;
  int             loads     = 0;

  matrix_loader #(.DATA_WIDTH(DW), .SIZE(SZ), .ARRAY_SIZE(AS)) dut (
    .clk         (clk),
    .rst         (rst),
    .N           (N),
    .load_start  (load_start),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .GLOBAL_DONE (GLOBAL_DONE),
    .A_matrix    (A_matrix),
    .B_matrix    (B_matrix),
    .START       (START),
    .busy        (busy),
    .size_err    (size_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic cmp_mat(input string name, input logic [TOT-1:0] act, input logic [TOT-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      for (int e = 0; e < AS; e++) begin
        if (act[(AS-e)*DW-1 -: DW] !== exp[(AS-e)*DW-1 -: DW]) begin
          $display("FAIL %s elem=%0d got=%0h exp=%0h", name, e,
                   act[(AS-e)*DW-1 -: DW], exp[(AS-e)*DW-1 -: DW]);
          break;
        end
      end
    end
  endtask

  // Scoreboard consumer: every START must match a completed stimulus load.
  always @(negedge clk) begin
    if (rst === 1'b1 && START === 1'b1) begin
      exp_t x;
      start_cnt++;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL start_unexpected got=1 exp=0");
      end else begin
        x = sb.pop_front();
        cmp_mat("A_at_start", A_matrix, x.a);
        cmp_mat("B_at_start", B_matrix, x.b);
      end
    end
  end

  task automatic do_load(input load_rec_t t);
    logic [TOT-1:0] ea;
    logic [TOT-1:0] eb;
    exp_t           x;
    int             nn;
    ea = '0;
    eb = '0;
    nn = t.n * t.n;
    N = 4'(t.n);
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    N = 4'd0;
    chk("ready_after_start", 32'(in_ready), 32'd1);
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("err_clear_on_start", 32'(size_err), 32'd0);
    for (int k = 0; k < 2 * nn; k++) begin
      int j;
      int e;
      logic [DW-1:0] v;
      j = k % nn;
      e = (j / t.n) * SZ + (j % t.n);
      v = DW'(t.base + k * t.step);
      if (k < nn) ea[(AS-e)*DW-1 -: DW] = v;
      else        eb[(AS-e)*DW-1 -: DW] = v;
      if (t.gap) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = v;
      if (t.poke && k == nn + 1) begin
        load_start = 1'b1;
        N = 4'd2;
      end
      if (k == 2 * nn - 1) begin
        x.a = ea;
        x.b = eb;
        sb.push_back(x);
      end
      @(negedge clk);
      load_start = 1'b0;
      N = 4'd0;
    end
    in_valid = 1'b0;
    chk("start_after_last_b", 32'(START), 32'd1);
    @(negedge clk);
    chk("start_single_cycle", 32'(START), 32'd0);
    chk("busy_wait_done", 32'(busy), 32'd1);
    chk("ready_wait_done", 32'(in_ready), 32'd0);
    if (t.poke) begin
      load_start = 1'b1;
      N = 4'd2;
      @(negedge clk);
      load_start = 1'b0;
      N = 4'd0;
      chk("poke_wait_busy", 32'(busy), 32'd1);
      chk("poke_wait_ready", 32'(in_ready), 32'd0);
    end
    GLOBAL_DONE = 1'b1;
    @(negedge clk);
    GLOBAL_DONE = 1'b0;
    chk("idle_after_done", 32'(busy), 32'd0);
    cmp_mat("A_held_idle", A_matrix, ea);
    cmp_mat("B_held_idle", B_matrix, eb);
    last_a = ea;
    last_b = eb;
    loads++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    load_rec_t loads_tbl[5];
    bad_rec_t  bad_tbl[3];

    loads_tbl = '{
      '{n: 2, gap: 1'b0, base: 1,   step: 1, poke: 1'b0},
      '{n: 6, gap: 1'b1, base: 1,   step: 1, poke: 1'b0},
      '{n: 4, gap: 1'b0, base: 200, step: 3, poke: 1'b0},
      '{n: 3, gap: 1'b0, base: 100, step: 1, poke: 1'b1},
      '{n: 1, gap: 1'b0, base: 9,   step: 2, poke: 1'b0}
    };
    bad_tbl = '{
      '{n: 0,  exp_err: 1'b1},
      '{n: 7,  exp_err: 1'b1},
      '{n: 15, exp_err: 1'b1}
    };

    rst = 1'b0;
    N = 4'd0;
    load_start = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    GLOBAL_DONE = 1'b0;
    #1;
    cmp_mat("reset_A", A_matrix, '0);
    cmp_mat("reset_B", B_matrix, '0);
    chk("reset_start", 32'(START), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_ready", 32'(in_ready), 32'd0);
    chk("reset_err", 32'(size_err), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    do_load(loads_tbl[0]);

    foreach (bad_tbl[i]) begin
      N = 4'(bad_tbl[i].n);
      load_start = 1'b1;
      @(negedge clk);
      load_start = 1'b0;
      N = 4'd0;
      chk($sformatf("bad_n%0d_err", bad_tbl[i].n), 32'(size_err), 32'(bad_tbl[i].exp_err));
      chk($sformatf("bad_n%0d_busy", bad_tbl[i].n), 32'(busy), 32'd0);
      chk($sformatf("bad_n%0d_ready", bad_tbl[i].n), 32'(in_ready), 32'd0);
      cmp_mat("bad_A_kept", A_matrix, last_a);
      cmp_mat("bad_B_kept", B_matrix, last_b);
      @(negedge clk);
    end

    do_load(loads_tbl[1]);

    // Abort an N=4 load after 10 elements with an asynchronous reset.
    N = 4'd4;
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    N = 4'd0;
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1;
      in_data  = DW'(500 + k);
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    cmp_mat("abort_A_zero", A_matrix, '0);
    cmp_mat("abort_B_zero", B_matrix, '0);
    chk("abort_start", 32'(START), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_ready", 32'(in_ready), 32'd0);
    chk("abort_err", 32'(size_err), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 2; i < 5; i++) do_load(loads_tbl[i]);

    repeat (3) @(negedge clk);
    chk("start_pulse_count", 32'(start_cnt), 32'(loads));
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/matrix_loader.md
MATRIX_LOADER -- requirements
Module: matrix_loader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of one matrix element.
REQ-002 SHALL have parameter SIZE, default 6, maximum matrix dimension.
REQ-003 SHALL have parameter ARRAY_SIZE, default SIZE*SIZE, element count of one flat matrix bus.
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port N  input  4  dimension of the square matrices, sampled on load_start.
REQ-007 SHALL have port load_start  input  1  begin a load, honoured only in IDLE.
REQ-008 SHALL have port in_valid  input  1  in_data holds a valid element.
REQ-009 SHALL have port in_data  input  DATA_WIDTH  element stream: A row-major, then B row-major.
REQ-010 SHALL have port in_ready  output  1  loader accepts in_data this cycle.
REQ-011 SHALL have port GLOBAL_DONE  input  1  multiply-complete flag from the scheduler.
REQ-012 SHALL have port A_matrix  output  ARRAY_SIZE*DATA_WIDTH  packed A, to the scheduler.
REQ-013 SHALL have port B_matrix  output  ARRAY_SIZE*DATA_WIDTH  packed B, to the scheduler.
REQ-014 SHALL have port START  output  1  one-cycle pulse: A_matrix/B_matrix complete.
REQ-015 SHALL have port busy  output  1  high in every state except IDLE.
REQ-016 SHALL have port size_err  output  1  sticky: last load_start carried an illegal N.

Function
REQ-017 SHALL implement states IDLE, LOAD_A, LOAD_B, FIRE, WAIT_DONE.
REQ-018 SHALL, in IDLE on load_start with 1<=N<=SIZE: latch N, zero A_matrix and B_matrix, clear size_err, clear row/col counters, go to LOAD_A.
REQ-019 SHALL, in IDLE on load_start with N==0 or N>SIZE: set size_err, keep matrices, stay in IDLE.
REQ-020 SHALL ignore load_start outside IDLE; latched N is not changed mid-load.
REQ-021 SHALL drive in_ready high only in LOAD_A and LOAD_B; a transfer is in_valid&&in_ready.
REQ-022 SHALL write each transferred element (r,c), element index e=r*SIZE+c, to bits [(ARRAY_SIZE-e)*DATA_WIDTH-1 -: DATA_WIDTH] of the current matrix (row 0, column 0 at MSBs).
REQ-023 SHALL advance col per transfer; col wraps to 0 and row increments when col==N-1.
REQ-024 SHALL leave elements with r>=N or c>=N at zero.
REQ-025 SHALL, on the transfer of (N-1,N-1) in LOAD_A, reset row/col and go to LOAD_B.
REQ-026 SHALL, on the transfer of (N-1,N-1) in LOAD_B, go to FIRE.
REQ-027 SHALL assert START for exactly the single FIRE cycle, i.e. the cycle after the last B element transfer, then go to WAIT_DONE.
REQ-028 SHALL stall without state change on cycles with in_valid low; no bubble limit.
REQ-029 SHALL hold A_matrix/B_matrix stable from FIRE through WAIT_DONE and in IDLE until the next legal load_start.
REQ-030 SHALL leave WAIT_DONE for IDLE on the first cycle GLOBAL_DONE is high.
REQ-031 SHALL for N==1 pass LOAD_A and LOAD_B with one transfer each.

Reset
REQ-032 SHALL on rst low, at any time including mid-load, immediately set state IDLE, A_matrix=0, B_matrix=0, START=0, in_ready=0, busy=0, size_err=0, counters=0, latched N=0.
REQ-033 SHALL discard any partial load on reset; no element is retained.

Structure
REQ-034 SHALL take DATA_WIDTH/SIZE defaults and state encodings from the shared matrix-multiply package, common with the scheduler.
REQ-035 SHALL use one sub-module, rc_counter: row/col counter with N-bounded wrap and last-element flag.

Verification
REQ-036 SHALL test N=2, A={1,2,3,4}, B={5,6,7,8} streamed back-to-back -> START one cycle after element 8, A_matrix e0..e1=1,2, e6..e7=3,4, all others 0; B_matrix likewise with 5..8.
REQ-037 SHALL test N=6 with in_valid toggled every other cycle, 72 elements 1..72 -> A holds 1..36, B holds 37..72 in index order, START once.
REQ-038 SHALL test load_start with N=0 and with N=7 -> size_err=1, busy=0, matrices unchanged, in_ready=0.
REQ-039 SHALL test rst low after 10 elements of an N=4 load -> all outputs 0 same cycle; fresh N=4 load then completes correctly.
REQ-040 SHALL test load_start pulsed during LOAD_B and WAIT_DONE -> ignored; GLOBAL_DONE=1 in WAIT_DONE -> IDLE next cycle, matrices still held.
REQ-041 SHALL test N=1, elements 9 then 11 -> A e0=9, B e0=11, START two cycles after load_start's acceptance plus transfers.
